// File: rtl/scrambler_lane_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : scrambler_lane_ctrl_if
// Description : Payload stream handshake between the user source and the lane
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface scrambler_lane_ctrl_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;

    modport master (output s_data, output s_valid, output s_last, input  s_ready);
    modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface
`default_nettype wire

// File: rtl/scrambler_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scrambler_lane_ctrl
// Description : Frames one 32-bit TX lane as SOF/DATA/EOF ahead of the data
//               scrambler, fills gaps with idle K-words and inserts periodic
//               clock-compensation bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module scrambler_lane_ctrl #(
    parameter logic [31:0] P_IDLE_WORD = 32'h50BC50BC,
    parameter logic [3:0]  P_IDLE_CHAR = 4'b0101,
    parameter logic [31:0] P_SOF_WORD  = 32'h000000FB,
    parameter logic [31:0] P_EOF_WORD  = 32'h000000FD,
    parameter logic [31:0] P_ABT_WORD  = 32'h000000FE,
    parameter logic [31:0] P_CC_WORD   = 32'h1C1C1C1C,
    parameter int          P_CC_PERIOD = 4096,
    parameter int          P_CC_LEN    = 4,
    parameter int          P_MIN_GAP   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    scrambler_lane_ctrl_if.slave s_if,
    output logic                 o_scr_en,
    output logic [31:0]          o_scr_data,
    output logic [3:0]           o_scr_char,
    output logic                 o_underrun,
    output logic [15:0]          o_frame_cnt
);

    localparam int          CW         = $clog2(P_CC_PERIOD);
    localparam int          C_LEN_MAX  = (P_CC_LEN > P_MIN_GAP) ? P_CC_LEN : P_MIN_GAP;
    localparam int          LW         = $clog2(C_LEN_MAX + 1);
    localparam logic [CW-1:0] C_CC_MAX   = CW'(P_CC_PERIOD - 1);
    localparam logic [LW-1:0] C_GAP_LAST = LW'(P_MIN_GAP - 1);
    localparam logic [LW-1:0] C_CC_LAST  = LW'(P_CC_LEN - 1);
    localparam logic [3:0]  C_K0_CHAR  = 4'b0001;
    localparam logic [3:0]  C_CC_CHAR  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SOF     = 3'd1,
        ST_DATA    = 3'd2,
        ST_DISCARD = 3'd3,
        ST_EOF     = 3'd4,
        ST_GAP     = 3'd5,
        ST_CC      = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cc_cnt;
    logic [LW-1:0] r_len_cnt;
    logic          r_ready;
    logic          r_scr_en;
    logic [31:0]   r_scr_data;
    logic [3:0]    r_scr_char;
    logic          r_underrun;
    logic [15:0]   r_frame_cnt;

    logic          w_cc_pend;
    logic          w_en;
    logic [31:0]   w_data;
    logic [3:0]    w_char;
    logic          w_underrun;
    logic          w_frame_done;

    assign w_cc_pend = (r_cc_cnt == C_CC_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The word computed in a state is registered, so it leaves one cycle later.
    always_comb begin
        w_state_nxt  = r_state;
        w_en         = 1'b0;
        w_data       = P_IDLE_WORD;
        w_char       = P_IDLE_CHAR;
        w_underrun   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cc_pend) begin
                    w_state_nxt = ST_CC;
                end else if (s_if.s_valid) begin
                    w_state_nxt = ST_SOF;
                end
            end
            ST_SOF: begin
                w_data      = P_SOF_WORD;
                w_char      = C_K0_CHAR;
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (s_if.s_valid) begin
                    w_en   = 1'b1;
                    w_data = s_if.s_data;
                    w_char = 4'b0000;
                    if (s_if.s_last) begin
                        w_frame_done = 1'b1;
                        w_state_nxt  = ST_EOF;
                    end
                end else begin
                    w_data      = P_ABT_WORD;
                    w_char      = C_K0_CHAR;
                    w_underrun  = 1'b1;
                    w_state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (s_if.s_valid && s_if.s_last) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_EOF: begin
                w_data      = P_EOF_WORD;
                w_char      = C_K0_CHAR;
                w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (r_len_cnt == C_GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CC: begin
                w_data = P_CC_WORD;
                w_char = C_CC_CHAR;
                if (r_len_cnt == C_CC_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scr_en    <= 1'b0;
            r_scr_data  <= 32'h0;
            r_scr_char  <= 4'h0;
            r_underrun  <= 1'b0;
            r_ready     <= 1'b0;
            r_frame_cnt <= 16'h0;
            r_cc_cnt    <= '0;
            r_len_cnt   <= '0;
        end else begin
            r_scr_en   <= w_en;
            r_scr_data <= w_data;
            r_scr_char <= w_char;
            r_underrun <= w_underrun;
            r_ready    <= (w_state_nxt == ST_DATA) || (w_state_nxt == ST_DISCARD);
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            // The CC counter holds through a burst and restarts once it ends.
            if (r_state == ST_CC) begin
                if (w_state_nxt != ST_CC) begin
                    r_cc_cnt <= '0;
                end
            end else if (!w_cc_pend) begin
                r_cc_cnt <= r_cc_cnt + CW'(1);
            end
            if ((w_state_nxt == r_state) && ((r_state == ST_GAP) || (r_state == ST_CC))) begin
                r_len_cnt <= r_len_cnt + LW'(1);
            end else begin
                r_len_cnt <= '0;
            end
        end
    end

    assign s_if.s_ready = r_ready;
    assign o_scr_en     = r_scr_en;
    assign o_scr_data   = r_scr_data;
    assign o_scr_char   = r_scr_char;
    assign o_underrun   = r_underrun;
    assign o_frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_scrambler_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_scrambler_lane_ctrl
// Description : Directed self-checking bench for scrambler_lane_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scrambler_lane_ctrl;

    localparam logic [31:0] C_IDLE = 32'h50BC50BC;
    localparam logic [31:0] C_SOF  = 32'h000000FB;
    localparam logic [31:0] C_EOF  = 32'h000000FD;
    localparam logic [31:0] C_ABT  = 32'h000000FE;
    localparam logic [31:0] C_CC   = 32'h1C1C1C1C;

    logic        clk;
    logic        rst_n;
    logic        scr_en;
    logic [31:0] scr_data;
    logic [3:0]  scr_char;
    logic        underrun;
    logic [15:0] frame_cnt;

    int          total;
    int          bad;

    int          src_n;
    int          src_idx;
    int          src_hole;
    bit          hole_used;
    logic [31:0] src_base;

    scrambler_lane_ctrl_if sif ();

    scrambler_lane_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .s_if        (sif),
        .o_scr_en    (scr_en),
        .o_scr_data  (scr_data),
        .o_scr_char  (scr_char),
        .o_underrun  (underrun),
        .o_frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_src();
        if (src_idx < src_n) begin
            if ((src_idx == src_hole) && !hole_used) begin
                sif.s_valid = 1'b0;
                hole_used   = 1'b1;
            end else begin
                sif.s_valid = 1'b1;
                sif.s_data  = src_base + 32'(src_idx);
                sif.s_last  = (src_idx == src_n - 1);
            end
        end else begin
            sif.s_valid = 1'b0;
            sif.s_last  = 1'b0;
            sif.s_data  = 32'h0;
        end
    endtask

    task automatic start_src(input int n, input logic [31:0] base, input int hole);
        src_n     = n;
        src_base  = base;
        src_idx   = 0;
        src_hole  = hole;
        hole_used = 1'b0;
        drive_src();
    endtask

    // One clock: the handshake is judged on the values present before the edge.
    task automatic step();
        bit fire;
        fire = sif.s_ready && sif.s_valid;
        @(posedge clk);
        #1;
        if (fire) src_idx++;
        drive_src();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start_src(0, 32'h0, -1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_src(0, 32'h0, -1);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({scr_en, scr_data, scr_char, underrun, sif.s_ready, frame_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got en=%b data=%h char=%b ur=%b rdy=%b cnt=%0d want all zero",
                     scr_en, scr_data, scr_char, underrun, sif.s_ready, frame_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            total++;
            if (scr_data !== C_IDLE || scr_char !== 4'b0101 || scr_en !== 1'b0 || sif.s_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle[%0d]: got data=%h char=%b en=%b rdy=%b want 50bc50bc/0101/0/0",
                         k, scr_data, scr_char, scr_en, sif.s_ready);
            end
        end
    endtask

    task automatic test_frame();
        logic [31:0] exp_d [9];
        logic [3:0]  exp_c [9];
        logic        exp_e [9];
        exp_d = '{C_IDLE, C_SOF, 32'hA0000000, 32'hA0000001, 32'hA0000002, C_EOF, C_IDLE, C_IDLE, C_IDLE};
        exp_c = '{4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0101, 4'b0101, 4'b0101};
        exp_e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        start_src(3, 32'hA0000000, -1);
        for (int k = 0; k < 9; k++) begin
            step();
            total++;
            if (scr_data !== exp_d[k] || scr_char !== exp_c[k] || scr_en !== exp_e[k]) begin
                bad++;
                $display("FAIL frame_word[%0d]: got %h/%b/en%b want %h/%b/en%b",
                         k, scr_data, scr_char, scr_en, exp_d[k], exp_c[k], exp_e[k]);
            end
        end
        total++;
        if (frame_cnt !== 16'd1) begin
            bad++;
            $display("FAIL frame_cnt: got %0d want 1", frame_cnt);
        end
    endtask

    task automatic test_abort();
        int ur_cnt;
        int ur_step;
        int nonidle;
        ur_cnt  = 0;
        ur_step = -1;
        nonidle = 0;
        start_src(5, 32'hB0000000, 2);
        for (int k = 1; k <= 11; k++) begin
            step();
            if (underrun === 1'b1) begin
                ur_cnt++;
                ur_step = k;
            end
            if (k == 5) begin
                total++;
                if (scr_data !== C_ABT || scr_char !== 4'b0001 || scr_en !== 1'b0) begin
                    bad++;
                    $display("FAIL abort_word: got %h/%b/en%b want 000000fe/0001/en0", scr_data, scr_char, scr_en);
                end
            end
            if (k > 5 && (scr_data !== C_IDLE || scr_en !== 1'b0)) nonidle++;
        end
        total++;
        if (ur_cnt !== 1 || ur_step !== 5) begin
            bad++;
            $display("FAIL underrun_pulse: got count=%0d at step %0d want 1 at step 5", ur_cnt, ur_step);
        end
        total++;
        if (nonidle !== 0) begin
            bad++;
            $display("FAIL abort_discard: got %0d non-idle words want 0", nonidle);
        end
        total++;
        if (src_idx !== 5) begin
            bad++;
            $display("FAIL abort_drain: got %0d beats consumed want 5", src_idx);
        end
        total++;
        if (frame_cnt !== 16'd1) begin
            bad++;
            $display("FAIL abort_frame_cnt: got %0d want 1", frame_cnt);
        end
    endtask

    task automatic test_single_word();
        logic [31:0] exp_d [4];
        logic        exp_e [4];
        exp_d = '{C_IDLE, C_SOF, 32'hC0000000, C_EOF};
        exp_e = '{1'b0, 1'b0, 1'b1, 1'b0};
        start_src(1, 32'hC0000000, -1);
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (scr_data !== exp_d[k] || scr_en !== exp_e[k]) begin
                bad++;
                $display("FAIL single_word[%0d]: got %h/en%b want %h/en%b", k, scr_data, scr_en, exp_d[k], exp_e[k]);
            end
        end
        total++;
        if (frame_cnt !== 16'd2) begin
            bad++;
            $display("FAIL single_frame_cnt: got %0d want 2", frame_cnt);
        end
        repeat (4) step();
    endtask

    task automatic test_cc();
        int first;
        int second;
        int n_cc;
        int bad_cc;
        int other;
        first  = 0;
        second = 0;
        n_cc   = 0;
        bad_cc = 0;
        other  = 0;
        do_reset();
        for (int k = 1; k <= 8205; k++) begin
            step();
            if (scr_data === C_CC) begin
                n_cc++;
                if (scr_char !== 4'b1111 || scr_en !== 1'b0) bad_cc++;
                if (first == 0) first = k;
                else if (second == 0 && k > first + 4) second = k;
            end else if (scr_data !== C_IDLE || scr_char !== 4'b0101 || scr_en !== 1'b0) begin
                other++;
            end
        end
        total++;
        if (first !== 4097) begin
            bad++;
            $display("FAIL cc_first: got cycle %0d want 4097", first);
        end
        total++;
        if (second !== 8197) begin
            bad++;
            $display("FAIL cc_period: got cycle %0d want 8197", second);
        end
        total++;
        if (n_cc !== 8 || bad_cc !== 0) begin
            bad++;
            $display("FAIL cc_burst: got %0d cc words (%0d malformed) want 8 (0)", n_cc, bad_cc);
        end
        total++;
        if (other !== 0) begin
            bad++;
            $display("FAIL cc_idle_fill: got %0d stray words want 0", other);
        end
    endtask

    task automatic test_long_frame();
        int  got;
        int  cc_in;
        int  data_err;
        bit  eof_seen;
        got      = 0;
        cc_in    = 0;
        data_err = 0;
        eof_seen = 1'b0;
        do_reset();
        start_src(10000, 32'h10000000, -1);
        for (int k = 0; k < 10100 && !eof_seen; k++) begin
            step();
            if (scr_data === C_CC) cc_in++;
            if (scr_en === 1'b1) begin
                if (scr_data !== 32'h10000000 + 32'(got)) data_err++;
                got++;
            end
            if (scr_data === C_EOF && scr_char === 4'b0001) eof_seen = 1'b1;
        end
        total++;
        if (!eof_seen || got !== 10000 || data_err !== 0) begin
            bad++;
            $display("FAIL long_frame: got eof=%0d words=%0d errors=%0d want 1/10000/0", eof_seen, got, data_err);
        end
        total++;
        if (cc_in !== 0) begin
            bad++;
            $display("FAIL long_no_cc: got %0d cc words inside frame want 0", cc_in);
        end
        for (int j = 1; j <= 7; j++) begin
            step();
            total++;
            if (scr_data !== ((j <= 3) ? C_IDLE : C_CC) || scr_en !== 1'b0) begin
                bad++;
                $display("FAIL long_after_eof[%0d]: got %h/en%b want %h/en0",
                         j, scr_data, scr_en, (j <= 3) ? C_IDLE : C_CC);
            end
        end
        total++;
        if (frame_cnt !== 16'd1) begin
            bad++;
            $display("FAIL long_frame_cnt: got %0d want 1", frame_cnt);
        end
        repeat (2) step();
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] exp_d [5];
        exp_d = '{C_IDLE, C_SOF, 32'hD0000000, 32'hD0000001, C_EOF};
        start_src(10, 32'hE0000000, -1);
        repeat (6) step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({scr_en, scr_data, scr_char, underrun, sif.s_ready, frame_cnt} !== '0) begin
            bad++;
            $display("FAIL async_reset: got en=%b data=%h char=%b ur=%b rdy=%b cnt=%0d want all zero",
                     scr_en, scr_data, scr_char, underrun, sif.s_ready, frame_cnt);
        end
        start_src(0, 32'h0, -1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_src(2, 32'hD0000000, -1);
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (scr_data !== exp_d[k]) begin
                bad++;
                $display("FAIL post_reset_frame[%0d]: got %h want %h", k, scr_data, exp_d[k]);
            end
        end
        total++;
        if (frame_cnt !== 16'd1) begin
            bad++;
            $display("FAIL post_reset_cnt: got %0d want 1", frame_cnt);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        sif.s_data  = 32'h0;
        test_reset();
        test_frame();
        test_abort();
        test_single_word();
        test_cc();
        test_long_frame();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
